// File: rtl/defeat_pkg.sv
// Shared definitions for the game-over phase responder and the game-state FSM.
package defeat_pkg;

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_INTACT,
      PH_SPLIT,
      PH_SCATTER,
      PH_TEXT,
      PH_DONE
   } phase_t;

   localparam logic [3:0] ST_MENU      = 4'h0;
   localparam logic [3:0] ST_PLAYER    = 4'h1;
   localparam logic [3:0] ST_ENEMY     = 4'h8;
   localparam logic [3:0] ST_GAME_OVER = 4'hF;

   typedef logic [11:0] rgb444_t;

   localparam rgb444_t RGB_BLACK = 12'h000;

endpackage

// File: rtl/defeat_sequence_font_stamp.sv
// Combinational "GAME OVER" text stamp: reports whether the current pixel
// falls on a lit glyph cell of the string placed at ORIGIN, scaled by SCALE.
module font_stamp #(
   parameter int unsigned ORIGIN_X = 128,
   parameter int unsigned ORIGIN_Y = 128,
   parameter int unsigned SCALE    = 2
) (
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   output logic        in_sprite
);

   localparam int unsigned N_CHARS = 9;
   localparam logic [11:0] OX      = 12'(ORIGIN_X);
   localparam logic [11:0] OY      = 12'(ORIGIN_Y);
   localparam logic [11:0] TEXT_W  = 12'(N_CHARS * 8 * SCALE);
   localparam logic [11:0] TEXT_H  = 12'(8 * SCALE);

   function automatic logic [7:0] char_at(input logic [3:0] idx);
      case (idx)
         4'd0:    return "G";
         4'd1:    return "A";
         4'd2:    return "M";
         4'd3:    return "E";
         4'd5:    return "O";
         4'd6:    return "V";
         4'd7:    return "E";
         4'd8:    return "R";
         default: return " ";
      endcase
   endfunction

   // 8x8 glyphs, first row in the top byte, leftmost pixel in bit 7.
   function automatic logic [7:0] glyph_row(input logic [7:0] ch, input logic [2:0] r);
      logic [63:0] g;
      case (ch)
         "G":     g = 64'h3C42404E42423C00;
         "A":     g = 64'h1824427E42424200;
         "M":     g = 64'h42665A4242424200;
         "E":     g = 64'h7E40407C40407E00;
         "O":     g = 64'h3C42424242423C00;
         "V":     g = 64'h4242424224241800;
         "R":     g = 64'h7C42427C48444200;
         default: g = 64'h0;
      endcase
      return g[{3'd7 - r, 3'b000} +: 8];
   endfunction

   logic [11:0] x12;
   logic [11:0] y12;
   logic [11:0] dx;
   logic [11:0] dy;
   logic [6:0]  col;
   logic [2:0]  row;
   logic        in_x;
   logic        in_y;
   logic [7:0]  bits;

   assign x12  = {1'b0, hcount_in};
   assign y12  = {2'b00, vcount_in};
   assign dx   = x12 - OX;
   assign dy   = y12 - OY;
   assign in_x = (x12 >= OX) && (dx < TEXT_W);
   assign in_y = (y12 >= OY) && (dy < TEXT_H);
   assign col  = 7'(dx / 12'(SCALE));
   assign row  = 3'(dy / 12'(SCALE));
   assign bits = glyph_row(char_at(col[6:3]), row);

   assign in_sprite = in_x && in_y && bits[3'd7 - col[2:0]];

endmodule

// File: rtl/defeat_sequence.sv
// Game-over phase responder: heart intact -> split -> shard scatter -> text,
// then waits for a fresh press of decide_in before reporting finished.
module defeat_sequence
   import defeat_pkg::*;
#(
   parameter int unsigned HEART_X      = 496,
   parameter int unsigned HEART_Y      = 368,
   parameter rgb444_t     HEART_COLOR  = 12'h0F0,
   parameter rgb444_t     TEXT_COLOR   = 12'hFFF,
   parameter int unsigned T_INTACT     = 32500000,
   parameter int unsigned T_SPLIT      = 32500000,
   parameter int unsigned SHARD_FRAMES = 60,
   parameter logic [3:0]  GO_STATE     = ST_GAME_OVER
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic [3:0]  state_in,
   input  logic        decide_in,
   output logic        busy_out,
   output logic        finished_out,
   output rgb444_t     pixel_out
);

   localparam logic [11:0] HX = 12'(HEART_X);
   localparam logic [11:0] HY = 12'(HEART_Y);

   phase_t      phase_q, phase_d;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  offset_q, offset_d;
   logic        decide_prev_q, decide_prev_d;
   logic        armed_q, armed_d;
   logic        busy_q, busy_d;
   logic        finished_q, finished_d;
   rgb444_t     pixel_q, pixel_d;

   logic [11:0] x12, y12, off12;
   logic        go, frame_tick, decide_rise;
   logic        in_heart, split_gap, shard_hit, text_hit;
   logic        sx_left, sx_right, sy_top, sy_bot;

   assign x12         = {1'b0, hcount_in};
   assign y12         = {2'b00, vcount_in};
   assign off12       = {4'b0000, offset_q};
   assign go          = (state_in == GO_STATE);
   assign frame_tick  = (hcount_in == 11'd0) && (vcount_in == 10'd0);
   assign decide_rise = decide_in & ~decide_prev_q;

   assign in_heart  = (x12 >= HX) && (x12 <= HX + 12'd31) &&
                      (y12 >= HY) && (y12 <= HY + 12'd31);
   assign split_gap = (x12 == HX + 12'd15) || (x12 == HX + 12'd16);

   // Left/top shards are tested as coord+d against the heart origin so that
   // shards pushed past zero clip instead of wrapping.
   assign sx_left  = (x12 + off12 >= HX) && (x12 + off12 <= HX + 12'd7);
   assign sx_right = (x12 >= HX + 12'd24 + off12) && (x12 <= HX + 12'd31 + off12);
   assign sy_top   = (y12 + off12 >= HY) && (y12 + off12 <= HY + 12'd7);
   assign sy_bot   = (y12 >= HY + 12'd24 + off12) && (y12 <= HY + 12'd31 + off12);
   assign shard_hit = (sx_left || sx_right) && (sy_top || sy_bot);

   font_stamp #(
      .ORIGIN_X (128),
      .ORIGIN_Y (128),
      .SCALE    (2)
   ) u_text (
      .hcount_in (hcount_in),
      .vcount_in (vcount_in),
      .in_sprite (text_hit)
   );

   always_comb begin
      phase_d       = phase_q;
      cnt_d         = cnt_q;
      offset_d      = offset_q;
      busy_d        = busy_q;
      finished_d    = finished_q;
      pixel_d       = RGB_BLACK;
      decide_prev_d = decide_in;
      armed_d       = ~go;

      if (phase_q != PH_IDLE && !go) begin
         phase_d    = PH_IDLE;
         cnt_d      = 32'd0;
         offset_d   = 8'd0;
         busy_d     = 1'b0;
         finished_d = 1'b0;
      end else begin
         case (phase_q)
            PH_IDLE: begin
               // armed_q forces state_in to leave GO_STATE before a restart
               if (go && armed_q) begin
                  phase_d = PH_INTACT;
                  cnt_d   = 32'd0;
                  busy_d  = 1'b1;
               end
            end
            PH_INTACT: begin
               pixel_d = in_heart ? HEART_COLOR : RGB_BLACK;
               if (cnt_q == 32'(T_INTACT - 1)) begin
                  cnt_d   = 32'd0;
                  phase_d = PH_SPLIT;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            PH_SPLIT: begin
               pixel_d = (in_heart && !split_gap) ? HEART_COLOR : RGB_BLACK;
               if (cnt_q == 32'(T_SPLIT - 1)) begin
                  cnt_d    = 32'd0;
                  offset_d = 8'd0;
                  phase_d  = PH_SCATTER;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            PH_SCATTER: begin
               pixel_d = shard_hit ? HEART_COLOR : RGB_BLACK;
               if (frame_tick) begin
                  offset_d = offset_q + 8'd1;
                  if (offset_q == 8'(SHARD_FRAMES - 1)) phase_d = PH_TEXT;
               end
            end
            PH_TEXT: begin
               pixel_d = text_hit ? TEXT_COLOR : RGB_BLACK;
               if (decide_rise) begin
                  phase_d    = PH_DONE;
                  busy_d     = 1'b0;
                  finished_d = 1'b1;
               end
            end
            PH_DONE: begin
               pixel_d = text_hit ? TEXT_COLOR : RGB_BLACK;
            end
            default: phase_d = PH_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q       <= PH_IDLE;
         cnt_q         <= 32'd0;
         offset_q      <= 8'd0;
         decide_prev_q <= 1'b0;
         armed_q       <= 1'b0;
         busy_q        <= 1'b0;
         finished_q    <= 1'b0;
         pixel_q       <= RGB_BLACK;
      end else begin
         phase_q       <= phase_d;
         cnt_q         <= cnt_d;
         offset_q      <= offset_d;
         decide_prev_q <= decide_prev_d;
         armed_q       <= armed_d;
         busy_q        <= busy_d;
         finished_q    <= finished_d;
         pixel_q       <= pixel_d;
      end
   end

   assign busy_out     = busy_q;
   assign finished_out = finished_q;
   assign pixel_out    = pixel_q;

endmodule

// File: tb/tb_defeat_sequence.sv
// Directed walk through the game-over sequence followed by randomized play,
// all outputs compared every cycle against a behavioural model.
module tb_defeat_sequence;

   localparam int HX   = 496;
   localparam int HY   = 368;
   localparam int HC   = 12'h0F0;
   localparam int TC   = 12'hFFF;
   localparam int T_I  = 10;
   localparam int T_S  = 10;
   localparam int SF   = 3;
   localparam logic [3:0] GO = 4'hF;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [3:0]  state_in;
   logic        decide_in;
   logic        busy_out;
   logic        finished_out;
   logic [11:0] pixel_out;

   int n_cmp = 0;
   int n_bad = 0;

   // model: stage 0 idle, 1 intact, 2 split, 3 scatter, 4 text, 5 done
   int m_stage, m_cnt, m_off, m_pix;
   bit m_prev, m_left, m_busy, m_fin;

   defeat_sequence #(
      .T_INTACT     (T_I),
      .T_SPLIT      (T_S),
      .SHARD_FRAMES (SF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .hcount_in    (hcount_in),
      .vcount_in    (vcount_in),
      .state_in     (state_in),
      .decide_in    (decide_in),
      .busy_out     (busy_out),
      .finished_out (finished_out),
      .pixel_out    (pixel_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // -1 marks the text area, whose glyph shapes are checked only at known points
   function automatic int draw(int st, int x, int y, int d);
      bit in_box;
      int cx[2];
      int cy[2];
      in_box = x >= HX && x <= HX + 31 && y >= HY && y <= HY + 31;
      cx[0] = HX - d; cx[1] = HX + 24 + d;
      cy[0] = HY - d; cy[1] = HY + 24 + d;
      case (st)
         1: return in_box ? HC : 0;
         2: return (in_box && x != HX + 15 && x != HX + 16) ? HC : 0;
         3: begin
            for (int a = 0; a < 2; a++)
               for (int b = 0; b < 2; b++)
                  if (x >= cx[a] && x < cx[a] + 8 && y >= cy[b] && y < cy[b] + 8)
                     return HC;
            return 0;
         end
         4, 5: return (x >= 128 && x < 128 + 9 * 16 && y >= 128 && y < 144) ? -1 : 0;
         default: return 0;
      endcase
   endfunction

   task automatic tick(input bit r, input logic [3:0] st, input bit dec, input int x, input int y);
      bit go;
      int p;
      rst       = r;
      state_in  = st;
      decide_in = dec;
      hcount_in = 11'(x);
      vcount_in = 10'(y);
      @(posedge clk);
      go = (st == GO);
      if (r) begin
         m_stage = 0; m_cnt = 0; m_off = 0; m_prev = 0; m_left = 0;
         m_busy = 0; m_fin = 0; m_pix = 0;
      end else begin
         p = (m_stage != 0 && !go) ? 0 : draw(m_stage, x, y, m_off);
         if (m_stage != 0 && !go) begin
            m_stage = 0; m_cnt = 0; m_off = 0; m_busy = 0; m_fin = 0;
         end else begin
            case (m_stage)
               0: if (go && m_left) begin m_stage = 1; m_cnt = 0; m_busy = 1; end
               1: begin m_cnt++; if (m_cnt == T_I) begin m_cnt = 0; m_stage = 2; end end
               2: begin m_cnt++; if (m_cnt == T_S) begin m_cnt = 0; m_off = 0; m_stage = 3; end end
               3: if (x == 0 && y == 0) begin m_off++; if (m_off >= SF) m_stage = 4; end
               4: if (dec && !m_prev) begin m_stage = 5; m_busy = 0; m_fin = 1; end
               default: ;
            endcase
         end
         m_prev = dec;
         m_left = !go;
         m_pix  = p;
      end
      #1;
      check("busy", int'(busy_out), int'(m_busy));
      check("finished", int'(finished_out), int'(m_fin));
      if (m_pix >= 0) check("pixel", int'(pixel_out), m_pix);
   endtask

   initial begin
      int abort_left;
      bit dec;
      logic [3:0] st;
      int x, y;

      tick(1, 4'h0, 0, 0, 0);
      tick(1, 4'h0, 0, 0, 0);
      check("reset_busy", int'(busy_out), 0);
      check("reset_pix", int'(pixel_out), 0);
      repeat (100) tick(0, 4'h0, 0, HX + 15, HY);
      $display("idle: 100 cycles with state 0");

      tick(0, GO, 0, HX + 15, HY);
      check("start_busy", int'(busy_out), 1);
      for (int i = 0; i < 10; i++) begin
         tick(0, GO, 0, HX + 15, HY);
         check("intact_px", int'(pixel_out), HC);
      end
      for (int i = 0; i < 10; i++) begin
         tick(0, GO, 0, HX + 15, HY);
         check("split_px", int'(pixel_out), 0);
      end
      $display("heart: intact then split");

      tick(0, GO, 0, 0, 0);
      tick(0, GO, 0, HX - 1, HY - 1);
      check("shard_off1", int'(pixel_out), HC);
      tick(0, GO, 1, 0, 0);
      tick(0, GO, 1, HX - 2, HY - 2);
      check("shard_off2", int'(pixel_out), HC);
      tick(0, GO, 1, HX - 3, HY - 3);
      check("shard_out", int'(pixel_out), 0);
      tick(0, GO, 1, HX + 26, HY + 26);
      check("shard_br", int'(pixel_out), HC);
      tick(0, GO, 1, 0, 0);
      tick(0, GO, 1, 178, 128);
      check("text_lit", int'(pixel_out), TC);
      check("text_busy", int'(busy_out), 1);
      tick(0, GO, 1, 176, 128);
      check("text_dark", int'(pixel_out), 0);
      $display("scatter: three ticks into text");

      tick(0, GO, 1, 0, 0);
      repeat (5) tick(0, GO, 1, HX, HY);
      check("held_no_finish", int'(finished_out), 0);
      tick(0, GO, 0, HX, HY);
      tick(0, GO, 1, HX, HY);
      check("ack_finished", int'(finished_out), 1);
      check("ack_busy", int'(busy_out), 0);
      for (int i = 0; i < 20; i++) tick(0, GO, 1'($urandom_range(0, 1)), 178, 128);
      check("done_hold", int'(finished_out), 1);
      $display("ack: finished after fresh press");

      tick(1, GO, 0, HX, HY);
      check("rst_done_fin", int'(finished_out), 0);
      repeat (20) tick(0, GO, 0, HX + 15, HY);
      check("no_restart", int'(busy_out), 0);
      tick(0, 4'h0, 0, HX + 15, HY);
      tick(0, GO, 0, HX + 15, HY);
      check("reentry_busy", int'(busy_out), 1);
      $display("reset in done: restart only after re-entry");

      repeat (12) tick(0, GO, 0, HX + 15, HY);
      tick(0, 4'h0, 0, HX + 15, HY);
      check("abort_busy", int'(busy_out), 0);
      check("abort_pix", int'(pixel_out), 0);
      tick(0, GO, 0, HX + 15, HY);
      for (int i = 0; i < 10; i++) begin
         tick(0, GO, 0, HX + 15, HY);
         check("restart_px", int'(pixel_out), HC);
      end
      $display("abort: mid-split abort and clean restart");

      abort_left = 0;
      dec = 0;
      for (int i = 0; i < 4000; i++) begin
         if (abort_left == 0 && $urandom_range(0, 149) == 0) abort_left = $urandom_range(1, 5);
         if (abort_left > 0) begin
            abort_left--;
            st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'h8;
         end else begin
            st = GO;
         end
         if ($urandom_range(0, 5) == 0) dec = ~dec;
         if ($urandom_range(0, 9) == 0) begin
            x = 0; y = 0;
         end else if ($urandom_range(0, 9) == 0) begin
            x = $urandom_range(0, 2047); y = $urandom_range(0, 1023);
         end else begin
            x = HX - 12 + $urandom_range(0, 55);
            y = HY - 12 + $urandom_range(0, 55);
         end
         tick($urandom_range(0, 499) == 0, st, dec, x, y);
         if (i % 500 == 499) $display("random: %0d cycles, %0d compared", i + 1, n_cmp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
